// File: rtl/mem_port_arbiter.sv
// Arbitrates one pipelined single-port memory between the fetch (I) and data (D) ports.
// D wins by default; a starvation counter force-grants fetch; read data is routed back by tag.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   conflict_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;
    logic [15:0]       conflict_q, conflict_d;
    logic              force_i;

    always_comb begin
        force_i = i_req && (starve_q == STARVE_LIM);
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (force_i) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end
    end

    assign mem_en    = i_gnt | d_gnt;
    assign mem_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    assign mem_we    = d_gnt ? d_we : 4'b0000;
    assign mem_wdata = d_gnt ? d_wdata : 32'h0;

    always_comb begin
        if (i_gnt || !i_req) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // The freshly granted fetch enters stage 0 untouched, so a same-cycle flush spares it.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = i_gnt | (d_gnt & (d_we == 4'b0000));
        tag_id_d[0]  = d_gnt;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1] & ~(i_flush & ~tag_id_q[k-1]);
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    always_comb begin
        if (i_req && d_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= 4'd0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            conflict_q <= 16'd0;
        end else begin
            starve_q   <= starve_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            conflict_q <= conflict_d;
        end
    end

    assign i_rvalid     = tag_vld_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
    assign d_rvalid     = tag_vld_q[RD_LAT-1] & tag_id_q[RD_LAT-1];
    assign i_rdata      = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata      = d_rvalid ? mem_rdata : 32'h0;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RD_LAT=2 instance plus a RD_LAT=3 instance on shared inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, d_req;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata, mem_rdata;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr, conflict_cnt;

    logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, mem_en3;
    logic [31:0] i_rdata3, d_rdata3, mem_wdata3;
    logic [3:0]  mem_we3;
    logic [15:0] mem_addr3, conflict_cnt3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .RD_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.AW(16), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt3)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req     = 1'b0;
        i_addr    = 16'h0;
        i_flush   = 1'b0;
        d_req     = 1'b0;
        d_we      = 4'b0;
        d_addr    = 16'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic drain(input int n);
        idle_inputs();
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        @(negedge clk);
        n_chk++;
        if ({i_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== 55'h0) begin
            n_fail++;
            $display("FAIL reset_comb: got gnt_i=%b gnt_d=%b en=%b we=%h addr=%h, want all 0",
                     i_gnt, d_gnt, mem_en, mem_we, mem_addr);
        end
        n_chk++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_ret: got i_rv=%b d_rv=%b i_rd=%h d_rd=%h, want 0",
                     i_rvalid, d_rvalid, i_rdata, d_rdata);
        end
        n_chk++;
        if (conflict_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_conflict: got %h want 0000", conflict_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch_read();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        @(negedge clk);
        n_chk++;
        if ({i_gnt, d_gnt, mem_en, mem_addr, mem_we} !== {1'b1, 1'b0, 1'b1, 16'h0010, 4'h0}) begin
            n_fail++;
            $display("FAIL fetch_issue: got i_gnt=%b d_gnt=%b en=%b addr=%h we=%h, want 1 0 1 0010 0",
                     i_gnt, d_gnt, mem_en, mem_addr, mem_we);
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 2) mem_rdata = 32'hDEADBEEF;
            else        mem_rdata = 32'h5A5A5A5A;
            @(negedge clk);
            n_chk++;
            if (i_rvalid !== (c == 2) || i_rdata !== ((c == 2) ? 32'hDEADBEEF : 32'h0) || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_return c%0d: got i_rv=%b i_rd=%h d_rv=%b, want i_rv=%b",
                         c, i_rvalid, i_rdata, d_rvalid, (c == 2));
            end
        end
        drain(2);
    endtask

    task automatic test_starvation();
        logic exp_i;
        for (int c = 0; c < 6; c++) begin
            i_req  = 1'b1;
            i_addr = 16'h0100;
            d_req  = 1'b1;
            d_we   = 4'b0;
            d_addr = 16'h0200;
            exp_i  = (c == 4);
            @(negedge clk);
            n_chk++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || mem_addr !== (exp_i ? 16'h0100 : 16'h0200)) begin
                n_fail++;
                $display("FAIL starve c%0d: got i_gnt=%b d_gnt=%b addr=%h, want i_gnt=%b d_gnt=%b",
                         c, i_gnt, d_gnt, mem_addr, exp_i, !exp_i);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (conflict_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL conflict_cnt: got %0d want 6", conflict_cnt);
        end
        drain(5);
    endtask

    task automatic test_write();
        d_req   = 1'b1;
        d_we    = 4'b0011;
        d_addr  = 16'h0020;
        d_wdata = 32'h12345678;
        @(negedge clk);
        n_chk++;
        if ({d_gnt, i_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b101, 4'b0011, 16'h0020, 32'h12345678}) begin
            n_fail++;
            $display("FAIL write_issue: got d_gnt=%b en=%b we=%b addr=%h wdata=%h",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            idle_inputs();
            mem_rdata = 32'hFFFF0000;
            @(negedge clk);
            n_chk++;
            if (d_rvalid !== 1'b0 || d_rvalid3 !== 1'b0 || i_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL write_no_rvalid c%0d: got d_rv=%b d_rv3=%b i_rv=%b want 0",
                         c, d_rvalid, d_rvalid3, i_rvalid);
            end
        end
        drain(2);
    endtask

    task automatic test_flush();
        i_req  = 1'b1;
        i_addr = 16'h0030;
        next_cycle();
        i_flush = 1'b1;
        i_addr  = 16'h0031;
        @(negedge clk);
        n_chk++;
        if (i_gnt !== 1'b1 || mem_addr !== 16'h0031) begin
            n_fail++;
            $display("FAIL flush_grant: got i_gnt=%b addr=%h want 1 0031", i_gnt, mem_addr);
        end
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hAAAA0000;
        @(negedge clk);
        n_chk++;
        if (i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got i_rvalid=%b want 0", i_rvalid);
        end
        next_cycle();
        mem_rdata = 32'hBBBB1111;
        @(negedge clk);
        n_chk++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hBBBB1111) begin
            n_fail++;
            $display("FAIL flush_keep: got i_rvalid=%b i_rdata=%h want 1 BBBB1111", i_rvalid, i_rdata);
        end
        drain(4);
        // Data reads must survive a fetch flush.
        d_req  = 1'b1;
        d_addr = 16'h0050;
        next_cycle();
        idle_inputs();
        i_flush = 1'b1;
        next_cycle();
        idle_inputs();
        mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        n_chk++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001 || i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_d_kept: got d_rv=%b d_rd=%h i_rv=%b want 1 CAFE0001 0",
                     d_rvalid, d_rdata, i_rvalid);
        end
        drain(4);
    endtask

    task automatic test_latency3();
        logic        e2d, e2i, e3d, e3i;
        logic [31:0] rd;
        for (int c = 0; c <= 5; c++) begin
            idle_inputs();
            if (c == 0) begin
                d_req  = 1'b1;
                d_addr = 16'h0040;
            end
            if (c == 1) begin
                i_req  = 1'b1;
                i_addr = 16'h0041;
            end
            rd        = 32'hC0DE0000 + 32'(c);
            mem_rdata = rd;
            e2d = (c == 2);
            e2i = (c == 3);
            e3d = (c == 3);
            e3i = (c == 4);
            @(negedge clk);
            n_chk++;
            if (d_rvalid3 !== e3d || i_rvalid3 !== e3i ||
                d_rdata3 !== (e3d ? rd : 32'h0) || i_rdata3 !== (e3i ? rd : 32'h0)) begin
                n_fail++;
                $display("FAIL lat3 c%0d: got d_rv=%b d_rd=%h i_rv=%b i_rd=%h, want d_rv=%b i_rv=%b data=%h",
                         c, d_rvalid3, d_rdata3, i_rvalid3, i_rdata3, e3d, e3i, rd);
            end
            n_chk++;
            if (d_rvalid !== e2d || i_rvalid !== e2i ||
                d_rdata !== (e2d ? rd : 32'h0) || i_rdata !== (e2i ? rd : 32'h0)) begin
                n_fail++;
                $display("FAIL lat2 c%0d: got d_rv=%b d_rd=%h i_rv=%b i_rd=%h, want d_rv=%b i_rv=%b data=%h",
                         c, d_rvalid, d_rdata, i_rvalid, i_rdata, e2d, e2i, rd);
            end
            next_cycle();
        end
        drain(2);
    endtask

    task automatic test_reset_inflight();
        logic exp_i;
        i_req  = 1'b1;
        i_addr = 16'h0060;
        d_req  = 1'b1;
        d_addr = 16'h0070;
        next_cycle();
        d_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({i_rvalid, d_rvalid, conflict_cnt} !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_async: got i_rv=%b d_rv=%b conflict=%h want 0", i_rvalid, d_rvalid, conflict_cnt);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_rdata = 32'h77770000 + 32'(c);
            @(negedge clk);
            n_chk++;
            if ({i_rvalid, d_rvalid, i_rvalid3, d_rvalid3} !== 4'b0 || conflict_cnt !== 16'h0) begin
                n_fail++;
                $display("FAIL rst_quiet c%0d: got rv=%b%b%b%b conflict=%h want 0",
                         c, i_rvalid, d_rvalid, i_rvalid3, d_rvalid3, conflict_cnt);
            end
            next_cycle();
        end
        // A cleared starvation counter means D wins four more cycles before fetch is forced.
        for (int c = 0; c < 5; c++) begin
            i_req = 1'b1;
            d_req = 1'b1;
            exp_i = (c == 4);
            @(negedge clk);
            n_chk++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                n_fail++;
                $display("FAIL rst_starve c%0d: got i_gnt=%b d_gnt=%b want i_gnt=%b", c, i_gnt, d_gnt, exp_i);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (conflict_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL rst_conflict_restart: got %0d want 5", conflict_cnt);
        end
        drain(4);
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_starvation();
        test_write();
        test_flush();
        test_latency3();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
